// File: rtl/tile_collision_probe_pkg.sv
// Shared level geometry, tile codes and probe-stage state encoding.
package tile_collision_probe_pkg;

  localparam int LEVEL_W    = 2048;
  localparam int LEVEL_H    = 15;
  localparam int TILE_SHIFT = 3;
  localparam int SCREEN_W   = 160;
  localparam int SCREEN_H   = 120;
  localparam int ADDR_W     = 15;

  localparam logic [3:0] TILE_SKY = 4'd0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } probe_state_e;

  // Probe order: two left, two right, two up, two down.
  localparam logic [2:0] PROBE_LAST = 3'd7;

endpackage

// File: rtl/tile_collision_probe_addr_calc.sv
// Pixel coordinate to level tile address, with an out-of-level indication.
// Also used by drawBackground for its address math.
module tile_addr_calc
  import tile_collision_probe_pkg::*;
(
  input  logic [32:0]       px,
  input  logic [7:0]        py,
  output logic [ADDR_W-1:0] addr,
  output logic              out_of_range
);

  logic [32:0] col;
  logic [7:0]  row;

  // Full-width column/row so wrapped (negative) coordinates land out of range.
  always_comb begin
    col          = px >> TILE_SHIFT;
    row          = py >> TILE_SHIFT;
    out_of_range = (col >= 33'(LEVEL_W)) || (row >= 8'(LEVEL_H));
    addr         = ADDR_W'(33'(row) * 33'(LEVEL_W) + col);
  end

endmodule

// File: rtl/tile_collision_probe.sv
// Background collision probe: reads 8 tiles around the character box and
// reduces them to left/right/up/down blocked flags for the main game FSM.
module tile_collision_probe
  import tile_collision_probe_pkg::*;
#(
  parameter int SOLID_MIN   = 1,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [31:0]       x_location,
  input  logic [6:0]        y_location,
  input  logic [4:0]        width,
  input  logic [4:0]        height,
  input  logic [3:0]        tile_code,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_busy,
  output logic              left,
  output logic              right,
  output logic              up,
  output logic              down,
  output logic              done
);

  probe_state_e state_q, state_d;

  logic [2:0]  cnt_q;
  logic [31:0] x_q;
  logic [6:0]  y_q;
  logic [4:0]  w_q, h_q;

  logic [32:0] xs, ws, probe_x;
  logic [7:0]  ys, hs, probe_y;
  logic        probe_edge;
  logic [ADDR_W-1:0] probe_addr;
  logic        probe_oor;

  logic        vld_p [0:MEM_LATENCY];
  logic [2:0]  idx_p [0:MEM_LATENCY];
  logic        frc_p [0:MEM_LATENCY];

  logic        cap_hit, last_cap;
  logic [7:0]  res_q, res_d;

  logic        issuing, busy_d;
  logic [ADDR_W-1:0] addr_d;

  function automatic logic [3:0] side_flags(input logic [7:0] r);
    return {r[0] | r[1], r[2] | r[3], r[4] | r[5], r[6] | r[7]};
  endfunction

  tile_addr_calc u_calc (
    .px           (probe_x),
    .py           (probe_y),
    .addr         (probe_addr),
    .out_of_range (probe_oor)
  );

  // Probe coordinate for the current counter value; edge cases forced solid.
  always_comb begin
    xs         = {1'b0, x_q};
    ys         = {1'b0, y_q};
    ws         = {28'd0, w_q};
    hs         = {3'd0, h_q};
    probe_x    = xs;
    probe_y    = ys;
    probe_edge = 1'b0;
    case (cnt_q)
      3'd0: begin probe_x = xs - 33'd1; probe_edge = (x_q == '0); end
      3'd1: begin probe_x = xs - 33'd1; probe_y = ys + hs - 8'd1; probe_edge = (x_q == '0); end
      3'd2: begin probe_x = xs + ws; end
      3'd3: begin probe_x = xs + ws; probe_y = ys + hs - 8'd1; end
      3'd4: begin probe_y = ys - 8'd1; probe_edge = (y_q == '0); end
      3'd5: begin probe_x = xs + ws - 33'd1; probe_y = ys - 8'd1; probe_edge = (y_q == '0); end
      3'd6: begin probe_y = ys + hs; end
      default: begin probe_x = xs + ws - 33'd1; probe_y = ys + hs; end
    endcase
  end

  // Merge the returning tile (or forced result) into the 8-bit result vector.
  always_comb begin
    cap_hit  = frc_p[MEM_LATENCY] || (tile_code >= 4'(SOLID_MIN));
    res_d    = res_q;
    if (vld_p[MEM_LATENCY]) res_d[idx_p[MEM_LATENCY]] = cap_hit;
    last_cap = vld_p[MEM_LATENCY] && (idx_p[MEM_LATENCY] == PROBE_LAST);
  end

  // Next state, port ownership and next memory address.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (enable) state_d = ST_LATCH;
      ST_LATCH: state_d = enable ? ST_ISSUE : ST_IDLE;
      ST_ISSUE: begin
        if (!enable)                  state_d = ST_IDLE;
        else if (cnt_q == PROBE_LAST) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!enable)       state_d = ST_IDLE;
        else if (last_cap) state_d = ST_DONE;
      end
      ST_DONE:  if (!enable) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    issuing = (state_q == ST_ISSUE) && (state_d != ST_IDLE);
    busy_d  = ((state_q == ST_ISSUE) || (state_q == ST_DRAIN)) &&
              ((state_d == ST_ISSUE) || (state_d == ST_DRAIN));
    addr_d  = '0;
    if (issuing)     addr_d = probe_addr;
    else if (busy_d) addr_d = mem_addr;
  end

  // Control: state, counter, memory port, valid pipeline and flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      mem_addr <= '0;
      mem_busy <= 1'b0;
      left     <= 1'b0;
      right    <= 1'b0;
      up       <= 1'b0;
      down     <= 1'b0;
      for (int i = 0; i <= MEM_LATENCY; i++) vld_p[i] <= 1'b0;
    end else begin
      state_q  <= state_d;
      mem_addr <= addr_d;
      mem_busy <= busy_d;
      cnt_q    <= issuing ? cnt_q + 3'd1 : 3'd0;
      // Address stage: vld_p[0] lines up with mem_addr, vld_p[MEM_LATENCY] with tile_code.
      vld_p[0] <= issuing;
      for (int i = 1; i <= MEM_LATENCY; i++) vld_p[i] <= vld_p[i-1] && busy_d;
      if ((state_q == ST_DRAIN) && (state_d == ST_DONE))
        {left, right, up, down} <= side_flags(res_d);
    end
  end

  // Data: latched geometry, probe index/forced pipeline and result vector.
  always_ff @(posedge clock) begin
    if (state_q == ST_LATCH) begin
      x_q   <= x_location;
      y_q   <= y_location;
      w_q   <= width;
      h_q   <= height;
      res_q <= '0;
    end else begin
      res_q <= res_d;
    end
    idx_p[0] <= cnt_q;
    frc_p[0] <= probe_edge | probe_oor;
    for (int i = 1; i <= MEM_LATENCY; i++) begin
      idx_p[i] <= idx_p[i-1];
      frc_p[i] <= frc_p[i-1];
    end
  end

  assign done = (state_q == ST_DONE);

endmodule
